vol_meter_ph: RTL and testbench
===============================

Name: vol_meter_ph

Overview:
- Parametrised windowed peak level meter with decay smoothing and peak-hold marker, driving an LED bar graph and a level code for the display path.
- Consumes unsigned sample magnitudes from the audio capture path, qualified by sample_valid.
- Takes the maximum over a window of WINDOW accepted samples and quantises it to LEVEL_W bits.
- Smooths the bar with per-window decay and keeps a held peak marker.

Parameters:
- SAMPLE_W, 10, width of unsigned input magnitude.
- WINDOW, 2000, accepted samples per measurement window; must be >= 2.
- LEVEL_W, 4, width of the quantised level; must be <= SAMPLE_W.
- NUM_LEDS, 12, bar graph length.
- DECAY_STEP, 1, levels the displayed bar drops per window when the signal falls.
- HOLD_WINDOWS, 8, windows the peak marker is held before it starts falling; must be >= 1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous clear; same effect as reset, takes priority over sample_valid.
- sample_valid, input, 1, in_wave is accepted on this cycle.
- in_wave, input, SAMPLE_W, unsigned sample magnitude.
- level, output, LEVEL_W, raw quantised peak of the last completed window.
- disp_level, output, LEVEL_W, smoothed (decaying) level.
- peak_level, output, LEVEL_W, held peak level.
- level_valid, output, 1, one-cycle pulse when a window closes.
- led, output, NUM_LEDS, bar graph with peak marker.

Behaviour:
- Reset and clear: win_cnt, win_max, level, disp_level, peak_level, hold_cnt, led and level_valid all go to 0. The hold FSM goes to TRACK.
- Accepted sample: on every cycle with sample_valid, m = max(win_max, in_wave) and win_cnt increments.
- Window close: when the accepted sample has win_cnt == WINDOW-1:
  - The closing sample is included in m.
  - win_max <= 0 and win_cnt <= 0.
  - q = m[SAMPLE_W-1 -: LEVEL_W]; level <= q.
  - level_valid <= 1 for exactly one cycle.
  - disp_level, peak_level and led update on this same edge.
  - Latency: all outputs are visible the cycle after the edge that accepts the closing sample.
- Between windows: no output changes. Cycles without sample_valid do not advance win_cnt.
- Smoothing:
  - If q >= disp_level, then disp_level <= q.
  - Otherwise disp_level <= max(q, disp_level - DECAY_STEP), saturating with no underflow.
- Hold FSM, evaluated only at window close, using d = new disp_level:
  - TRACK: if d >= peak_level, then peak_level <= d and stay in TRACK. Otherwise go to HOLD with hold_cnt <= 1.
  - HOLD: if d >= peak_level, then peak_level <= d and go to TRACK. Else if hold_cnt == HOLD_WINDOWS, go to FALL. Else hold_cnt++.
  - FALL: peak_level <= max(d, peak_level - 1). Go to TRACK when the result equals d, or when d >= peak_level (in which case peak_level <= d).
  - A new higher peak in any state restarts tracking.
- LED mapping, from the new disp_level (d) and peak_level (p):
  - lit(x) = 0 if x == 0, else ((x+1)*NUM_LEDS) >> LEVEL_W.
  - led[i] = 1 for i < lit(d).
  - If p > 0, led[lit(p)-1] = 1 (marker).
  - Widths are wide enough that no intermediate product overflows.
- Simultaneous clear and sample_valid: clear wins and the sample is dropped.
- rst_n asserted mid-window: everything is cleared immediately, asynchronously.

Optional Feature:
- Macro: VOL_PEAK_HOLD_EN.
- Defined: hold FSM, hold_cnt and marker behave as above.
- Undefined: no FSM or hold counter is built. peak_level always equals disp_level, and led is the plain bar.

Test Plan:
- WINDOW=4, defaults. Samples 100, 1023, 50, 200 -> after the 4th sample: level=15, disp_level=15, led=12'hFFF, level_valid pulses once.
- Next window max 0 -> level=0, disp_level=14, peak_level=15, led=12'h7FF | marker bit 11 = 12'hFFF. Continue zero windows -> peak_level stays 15 for 8 windows, then falls by 1 per window. disp_level reaches 0 after 15 windows.
- Closing sample is the window max (0, 0, 0, 640) -> level=10; disp_level=10; lit=8 so led[7:0] set.
- sample_valid low for 10 cycles mid-window -> win_cnt frozen, no level_valid until 4 accepted samples.
- clear asserted together with sample_valid=1, in_wave=1023 -> all outputs 0, the next window starts from count 0 with max 0.
- rst_n pulsed low mid-window after sample 900 -> outputs 0 asynchronously; the next window reports only samples accepted after release.
- Build without VOL_PEAK_HOLD_EN and repeat the second scenario -> peak_level == disp_level every window.

Source files
------------

// File: rtl/vol_meter_ph.sv
// vol_meter_ph: windowed peak level meter with decay smoothing and peak-hold marker.
//
// Takes the maximum of WINDOW accepted sample magnitudes, quantises it to LEVEL_W
// bits, smooths it with a per-window decay and drives an LED bar graph.
//
// Optional feature macro: VOL_PEAK_HOLD_EN
//   defined   -> peak-hold FSM (TRACK/HOLD/FALL), hold counter and bar marker
//   undefined -> peak_level follows disp_level and led is the plain bar
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   clear        synchronous clear, same effect as reset, beats sample_valid
//   sample_valid in_wave is accepted this cycle
//   in_wave      unsigned sample magnitude
//   level        raw quantised peak of the last completed window
//   disp_level   smoothed (decaying) level
//   peak_level   held peak level
//   level_valid  one-cycle pulse when a window closes
//   led          bar graph with peak marker
module vol_meter_ph #(
    parameter int unsigned SAMPLE_W     = 10,
    parameter int unsigned WINDOW       = 2000,
    parameter int unsigned LEVEL_W      = 4,
    parameter int unsigned NUM_LEDS     = 12,
    parameter int unsigned DECAY_STEP   = 1,
    parameter int unsigned HOLD_WINDOWS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] in_wave,
    output logic [LEVEL_W-1:0]  level,
    output logic [LEVEL_W-1:0]  disp_level,
    output logic [LEVEL_W-1:0]  peak_level,
    output logic                level_valid,
    output logic [NUM_LEDS-1:0] led
);

    localparam int unsigned CntW = (WINDOW > 2) ? $clog2(WINDOW) : 1;

    logic [CntW-1:0]     win_cnt_q, win_cnt_d;
    logic [SAMPLE_W-1:0] win_max_q, win_max_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [LEVEL_W-1:0]  disp_q, disp_d;
    logic [LEVEL_W-1:0]  peak_q, peak_d;
    logic                valid_q, valid_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    logic [SAMPLE_W-1:0] m;
    logic [LEVEL_W-1:0]  q;
    logic [LEVEL_W-1:0]  decayed;
    int unsigned         lit_d, lit_p;

    // Number of bar segments lit for a given level.
    function automatic int unsigned lit(input logic [LEVEL_W-1:0] x);
        if (x == '0) begin
            return 0;
        end
        return ((32'(x) + 32'd1) * NUM_LEDS) >> LEVEL_W;
    endfunction

`ifdef VOL_PEAK_HOLD_EN
    localparam int unsigned HoldW = $clog2(HOLD_WINDOWS + 1);

    typedef enum logic [1:0] {StTrack, StHold, StFall} hold_state_e;

    hold_state_e      state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [LEVEL_W-1:0] peak_dec;
`endif

    assign m = (in_wave > win_max_q) ? in_wave : win_max_q;
    assign q = m[SAMPLE_W-1 -: LEVEL_W];

    always_comb begin
        win_cnt_d = win_cnt_q;
        win_max_d = win_max_q;
        level_d   = level_q;
        disp_d    = disp_q;
        peak_d    = peak_q;
        valid_d   = 1'b0;
        led_d     = led_q;
        decayed   = '0;
        lit_d     = 0;
        lit_p     = 0;
`ifdef VOL_PEAK_HOLD_EN
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        peak_dec   = '0;
`endif

        if (clear) begin
            win_cnt_d = '0;
            win_max_d = '0;
            level_d   = '0;
            disp_d    = '0;
            peak_d    = '0;
            led_d     = '0;
`ifdef VOL_PEAK_HOLD_EN
            state_d    = StTrack;
            hold_cnt_d = '0;
`endif
        end else if (sample_valid) begin
            if (win_cnt_q == CntW'(WINDOW - 1)) begin
                win_cnt_d = '0;
                win_max_d = '0;
                level_d   = q;
                valid_d   = 1'b1;

                // Saturating decay, never below the fresh window level.
                if (32'(disp_q) > DECAY_STEP) begin
                    decayed = LEVEL_W'(32'(disp_q) - DECAY_STEP);
                end
                disp_d = (q >= disp_q) ? q : ((q > decayed) ? q : decayed);

`ifdef VOL_PEAK_HOLD_EN
                unique case (state_q)
                    StTrack: begin
                        if (disp_d >= peak_q) begin
                            peak_d = disp_d;
                        end else begin
                            state_d    = StHold;
                            hold_cnt_d = HoldW'(1);
                        end
                    end
                    StHold: begin
                        if (disp_d >= peak_q) begin
                            peak_d  = disp_d;
                            state_d = StTrack;
                        end else if (hold_cnt_q == HoldW'(HOLD_WINDOWS)) begin
                            state_d = StFall;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HoldW'(1);
                        end
                    end
                    default: begin
                        // In FALL peak is strictly above disp, so peak >= 1 here.
                        peak_dec = peak_q - LEVEL_W'(1);
                        if (disp_d >= peak_q) begin
                            peak_d  = disp_d;
                            state_d = StTrack;
                        end else begin
                            peak_d = (disp_d > peak_dec) ? disp_d : peak_dec;
                            if (peak_d == disp_d) begin
                                state_d = StTrack;
                            end
                        end
                    end
                endcase
`else
                peak_d = disp_d;
`endif

                lit_d = lit(disp_d);
                lit_p = lit(peak_d);
                for (int i = 0; i < int'(NUM_LEDS); i++) begin
                    led_d[i] = (i < int'(lit_d));
`ifdef VOL_PEAK_HOLD_EN
                    if ((peak_d != '0) && (i == int'(lit_p) - 1)) begin
                        led_d[i] = 1'b1;
                    end
`endif
                end
            end else begin
                win_cnt_d = win_cnt_q + CntW'(1);
                win_max_d = m;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
            win_max_q <= '0;
            level_q   <= '0;
            disp_q    <= '0;
            peak_q    <= '0;
            valid_q   <= 1'b0;
            led_q     <= '0;
`ifdef VOL_PEAK_HOLD_EN
            state_q    <= StTrack;
            hold_cnt_q <= '0;
`endif
        end else begin
            win_cnt_q <= win_cnt_d;
            win_max_q <= win_max_d;
            level_q   <= level_d;
            disp_q    <= disp_d;
            peak_q    <= peak_d;
            valid_q   <= valid_d;
            led_q     <= led_d;
`ifdef VOL_PEAK_HOLD_EN
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign level       = level_q;
    assign disp_level  = disp_q;
    assign peak_level  = peak_q;
    assign level_valid = valid_q;
    assign led         = led_q;

endmodule

// File: tb/tb_vol_meter_ph.sv
// Scoreboard bench for vol_meter_ph with WINDOW=4 and otherwise default parameters.
// Expected window results are pushed when the closing sample is driven; a monitor
// pops and compares whenever level_valid is seen.
module tb_vol_meter_ph;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        sample_valid = 1'b0;
    logic [9:0]  in_wave = '0;
    logic [3:0]  level, disp_level, peak_level;
    logic        level_valid;
    logic [11:0] led;

    typedef struct packed {
        logic [3:0]  lvl;
        logic [3:0]  disp;
        logic [3:0]  peak;
        logic [11:0] led;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pulse = 0;

    // Hand-computed lit(x) = ((x+1)*12)>>4, lit(0)=0.
    int lit_tab[16] = '{0, 1, 2, 3, 3, 4, 5, 6, 6, 7, 8, 9, 9, 10, 11, 12};

    vol_meter_ph #(
        .SAMPLE_W    (10),
        .WINDOW      (4),
        .LEVEL_W     (4),
        .NUM_LEDS    (12),
        .DECAY_STEP  (1),
        .HOLD_WINDOWS(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .sample_valid(sample_valid),
        .in_wave     (in_wave),
        .level       (level),
        .disp_level  (disp_level),
        .peak_level  (peak_level),
        .level_valid (level_valid),
        .led         (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [11:0] led_of(input int d, input int p);
        logic [11:0] v;
        v = '0;
        for (int i = 0; i < lit_tab[d]; i++) v[i] = 1'b1;
`ifdef VOL_PEAK_HOLD_EN
        if (p != 0) v[lit_tab[p] - 1] = 1'b1;
`endif
        return v;
    endfunction

    function automatic exp_t mk(input int lv, input int d, input int p);
        exp_t e;
        e.lvl  = 4'(lv);
        e.disp = 4'(d);
`ifdef VOL_PEAK_HOLD_EN
        e.peak = 4'(p);
        e.led  = led_of(d, p);
`else
        e.peak = 4'(d);
        e.led  = led_of(d, d);
`endif
        return e;
    endfunction

    // Monitor: compare every window result against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && level_valid) begin
            exp_t e;
            n_pulse++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_level_valid: got pulse, expected none");
            end else begin
                e = exp_q.pop_front();
                check("level", int'(level), int'(e.lvl));
                check("disp_level", int'(disp_level), int'(e.disp));
                check("peak_level", int'(peak_level), int'(e.peak));
                check("led", int'(led), int'(e.led));
            end
        end
    end

    task automatic send(input int v);
        @(negedge clk);
        sample_valid = 1'b1;
        in_wave = 10'(v);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        sample_valid = 1'b0;
        in_wave = '0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, "_level"}, int'(level), 0);
        check({name, "_disp"}, int'(disp_level), 0);
        check({name, "_peak"}, int'(peak_level), 0);
        check({name, "_valid"}, int'(level_valid), 0);
        check({name, "_led"}, int'(led), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pk;
        int pulses_exp;
        pulses_exp = 0;

        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full-scale window.
        send(100); send(1023); send(50);
        exp_q.push_back(mk(15, 15, 15)); pulses_exp++;
        send(200);
        idle(3);

        // Silent windows: bar decays, marker holds then falls.
        for (int j = 1; j <= 16; j++) begin
            pk = (j <= 9) ? 15 : 24 - j;
            send(0); send(0); send(0);
            exp_q.push_back(mk(0, (j <= 15) ? 15 - j : 0, pk)); pulses_exp++;
            send(0);
        end
        idle(3);

        // Closing sample carries the window maximum: 640 -> level 10.
        send(0); send(0); send(0);
        exp_q.push_back(mk(10, 10, 10)); pulses_exp++;
        send(640);
        idle(3);

        // Gap in sample_valid freezes the window count; 64 -> level 1, bar decays to 9.
        send(64);
        idle(10);
        send(0); send(0);
        exp_q.push_back(mk(1, 9, 10)); pulses_exp++;
        send(0);
        idle(3);

        // Clear mid-window with a concurrent full-scale sample that must be dropped.
        send(1023); send(1023);
        @(negedge clk);
        clear = 1'b1; sample_valid = 1'b1; in_wave = 10'd1023;
        @(negedge clk);
        clear = 1'b0; sample_valid = 1'b0;
        check_zero("clear");
        send(64); send(64); send(64);
        exp_q.push_back(mk(1, 1, 1)); pulses_exp++;
        send(64);
        idle(3);

        // Asynchronous reset mid-window.
        send(900);
        @(negedge clk);
        sample_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send(128); send(0); send(0);
        exp_q.push_back(mk(2, 2, 2)); pulses_exp++;
        send(0);
        idle(5);

        check("scoreboard_drained", exp_q.size(), 0);
        check("pulse_count", n_pulse, pulses_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
